// File: rtl/fetch_queue_unit.sv
// Fetch stage: credit-throttled I-cache line requests, in-order line queue, per-lane realignment, redirect squashing.
// Optional perf counters (perf_redirects/perf_dropped/perf_starved) are built when FETCH_PERF_EN is defined.
module fetch_queue_unit #(
  parameter int unsigned LANES    = 2,
  parameter int unsigned QDEPTH   = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [31:0]         imem_req_addr,
  input  logic                imem_rsp_valid,
  input  logic [32*LANES-1:0] imem_rsp_data,
  output logic [LANES-1:0]    out_valid,
  output logic [32*LANES-1:0] out_insn,
  output logic [32*LANES-1:0] out_pc,
`ifdef FETCH_PERF_EN
  output logic [31:0]         perf_redirects,
  output logic [31:0]         perf_dropped,
  output logic [31:0]         perf_starved,
`endif
  input  logic                out_ready
);

  localparam int unsigned LINE_BYTES = 4 * LANES;
  localparam int unsigned OFF        = $clog2(LINE_BYTES);
  localparam int unsigned LW         = OFF - 2;
  localparam int unsigned AW         = $clog2(QDEPTH);
  localparam logic [31:0] LINE_MASK  = ~(32'(LINE_BYTES) - 32'd1);
  localparam logic [AW+1:0] CREDITS  = (AW + 2)'(QDEPTH);
  localparam logic [AW:0] CNT_ZERO   = {(AW + 1){1'b0}};
  localparam logic [AW:0] CNT_ONE    = {{AW{1'b0}}, 1'b1};

  logic [31:0]         pc;
  logic [31:0]         pf_mem [QDEPTH];
  logic [31:0]         q_pc   [QDEPTH];
  logic [32*LANES-1:0] q_data [QDEPTH];
  logic [AW:0]         q_wr, q_rd, pf_wr, pf_rd, outstanding, drop_cnt;
  logic [AW:0]         q_count, rsp_dec, acc_inc;
  logic [AW+1:0]       credit_used;
  logic                q_empty, q_full, pf_empty, accept, q_push, q_pop, head_valid;
  logic [31:0]         head_pc, head_base;
  logic [LW-1:0]       start;

  assign q_count        = q_wr - q_rd;
  assign q_empty        = (q_wr == q_rd);
  assign q_full         = (q_wr[AW] != q_rd[AW]) && (q_wr[AW-1:0] == q_rd[AW-1:0]);
  assign pf_empty       = (pf_wr == pf_rd);
  assign credit_used    = {1'b0, q_count} + {1'b0, outstanding};
  assign imem_req_valid = !reset && !redirect_valid && (credit_used < CREDITS);
  assign imem_req_addr  = reset ? 32'h0 : (pc & LINE_MASK);
  assign accept         = imem_req_valid && imem_req_ready;
  assign rsp_dec        = imem_rsp_valid ? CNT_ONE : CNT_ZERO;
  assign acc_inc        = accept ? CNT_ONE : CNT_ZERO;
  assign q_push         = imem_rsp_valid && (drop_cnt == CNT_ZERO) && !redirect_valid;
  assign head_pc        = q_pc[q_rd[AW-1:0]];
  assign head_base      = head_pc & LINE_MASK;
  assign start          = head_pc[OFF-1:2];
  assign head_valid     = !reset && !redirect_valid && !q_empty;
  assign q_pop          = (|out_valid) && out_ready;

  // Head-entry realignment: lanes before the fetch PC's word offset are masked and zeroed.
  always_comb begin
    out_valid = {LANES{1'b0}};
    out_insn  = {(32 * LANES){1'b0}};
    out_pc    = {(32 * LANES){1'b0}};
    for (int i = 0; i < LANES; i++) begin
      if (head_valid && (LW'(i) >= start)) begin
        out_valid[i]        = 1'b1;
        out_insn[32*i +: 32] = q_data[q_rd[AW-1:0]][32*i +: 32];
        out_pc[32*i +: 32]   = head_base + 32'(4 * i);
      end else begin
        out_valid[i]        = 1'b0;
        out_insn[32*i +: 32] = 32'h0;
        out_pc[32*i +: 32]   = 32'h0;
      end
    end
  end

  // Control state: PC, pointers, in-flight and drop accounting.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      q_wr        <= CNT_ZERO;
      q_rd        <= CNT_ZERO;
      pf_wr       <= CNT_ZERO;
      pf_rd       <= CNT_ZERO;
      outstanding <= CNT_ZERO;
      drop_cnt    <= CNT_ZERO;
    end else if (redirect_valid) begin
      pc          <= redirect_pc;
      q_rd        <= q_wr;
      pf_rd       <= pf_wr;
      outstanding <= outstanding - rsp_dec;
      // Lines already pending drop are still part of outstanding, so this covers every in-flight line once.
      drop_cnt    <= outstanding - rsp_dec;
    end else begin
      outstanding <= outstanding + acc_inc - rsp_dec;
      if (accept) begin
        pc    <= (pc & LINE_MASK) + 32'(LINE_BYTES);
        pf_wr <= pf_wr + CNT_ONE;
      end
      // Squashed lines lost their pc-FIFO entries in the flush, so a drop never pops it.
      if (imem_rsp_valid && (drop_cnt != CNT_ZERO)) begin
        drop_cnt <= drop_cnt - CNT_ONE;
      end
      if (q_push) begin
        q_wr  <= q_wr + CNT_ONE;
        pf_rd <= pf_rd + CNT_ONE;
      end
      if (q_pop) begin
        q_rd <= q_rd + CNT_ONE;
      end
    end
  end

  // Payload storage for pc-FIFO and line queue.
  always_ff @(posedge clk) begin
    if (accept) begin
      pf_mem[pf_wr[AW-1:0]] <= pc;
    end
    if (q_push && !reset) begin
      q_pc[q_wr[AW-1:0]]   <= pf_mem[pf_rd[AW-1:0]];
      q_data[q_wr[AW-1:0]] <= imem_rsp_data;
    end
  end

`ifdef FETCH_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_redirects <= 32'h0;
      perf_dropped   <= 32'h0;
      perf_starved   <= 32'h0;
    end else begin
      if (redirect_valid) perf_redirects <= sat_inc(perf_redirects);
      if (imem_rsp_valid && (redirect_valid || (drop_cnt != CNT_ZERO))) perf_dropped <= sat_inc(perf_dropped);
      if (q_empty && out_ready) perf_starved <= sat_inc(perf_starved);
    end
  end
`endif

  fetch_queue_unit_checker #(.AW(AW)) u_checker (
    .clk         (clk),
    .reset       (reset),
    .q_push      (q_push),
    .q_full      (q_full),
    .rsp_valid   (imem_rsp_valid),
    .outstanding (outstanding),
    .drop_cnt    (drop_cnt),
    .pf_empty    (pf_empty)
  );

endmodule

// Simulation-time protocol checks for fetch_queue_unit.
module fetch_queue_unit_checker #(
  parameter int unsigned AW = 2
) (
  input logic        clk,
  input logic        reset,
  input logic        q_push,
  input logic        q_full,
  input logic        rsp_valid,
  input logic [AW:0] outstanding,
  input logic [AW:0] drop_cnt,
  input logic        pf_empty
);

  // Overflow, spurious response and pc-FIFO underflow checks.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(q_push && q_full));
      assert (!(rsp_valid && (outstanding == {(AW + 1){1'b0}})));
      assert (!(rsp_valid && (drop_cnt == {(AW + 1){1'b0}}) && pf_empty));
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit (LANES=2, QDEPTH=4) with a fixed-latency I-cache model whose word = address.
module tb_fetch_queue_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [63:0] imem_rsp_data  = 64'h0;
  logic [1:0]  out_valid;
  logic [63:0] out_insn;
  logic [63:0] out_pc;
  logic        out_ready;

  int checks = 0;
  int errors = 0;
  int lat    = 1;
  int cyc    = 0;

  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] req_log[$];
  logic [1:0]  pv[$];
  logic [31:0] pp0[$], pp1[$], pi0[$], pi1[$];

  always #5 clk = ~clk;

  fetch_queue_unit #(.LANES(2), .QDEPTH(4), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_insn       (out_insn),
    .out_pc         (out_pc),
    .out_ready      (out_ready)
  );

  // I-cache model plus request/pop monitors (sampled on pre-edge values).
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      mq_addr.delete();
      mq_due.delete();
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        mq_addr.push_back(imem_req_addr);
        mq_due.push_back(cyc + lat - 1);
        req_log.push_back(imem_req_addr);
      end
      if (out_ready && (|out_valid)) begin
        pv.push_back(out_valid);
        pp0.push_back(out_pc[31:0]);
        pp1.push_back(out_pc[63:32]);
        pi0.push_back(out_insn[31:0]);
        pi1.push_back(out_insn[63:32]);
      end
    end
    #1;
    if ((mq_addr.size() > 0) && (mq_due[0] <= cyc)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = {mq_addr[0] + 32'd4, mq_addr[0]};
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 64'h0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    req_log.delete();
    pv.delete();
    pp0.delete();
    pp1.delete();
    pi0.delete();
    pi1.delete();
  endtask

  task automatic do_reset(input int l, input logic rr, input logic orr);
    @(negedge clk);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    lat            = l;
    imem_req_ready = rr;
    out_ready      = orr;
    @(negedge clk);
    clear_logs();
    reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;

    // Reset state: every output low.
    @(negedge clk);
    #1;
    check("rst_req_valid", imem_req_valid, 64'h0);
    check("rst_req_addr",  imem_req_addr,  64'h0);
    check("rst_out_valid", out_valid,      64'h0);
    check("rst_out_insn",  out_insn,       64'h0);

    // Sequential fetch from RESET_PC.
    clear_logs();
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("seq_req0", req_log[0], 64'h0);
    check("seq_req1", req_log[1], 64'h8);
    check("seq_req2", req_log[2], 64'h10);
    check("seq_valid0", pv[0], 64'h3);
    check("seq_insn0", {pi1[0], pi0[0]}, 64'h0000_0004_0000_0000);
    check("seq_pc0",   {pp1[0], pp0[0]}, 64'h0000_0004_0000_0000);
    check("seq_pc1",   pp0[1], 64'h8);

    // Redirect to a mid-line PC.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h14;
    clear_logs();
    #1;
    check("redir_out_valid", out_valid, 64'h0);
    check("redir_req_valid", imem_req_valid, 64'h0);
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("redir_req0", req_log[0], 64'h10);
    check("redir_req1", req_log[1], 64'h18);
    check("redir_valid0", pv[0], 64'h2);
    check("redir_pc0", {pp1[0], pp0[0]}, 64'h0000_0014_0000_0000);
    check("redir_insn0", {pi1[0], pi0[0]}, 64'h0000_0014_0000_0000);
    check("redir_valid1", pv[1], 64'h3);
    check("redir_pc1", {pp1[1], pp0[1]}, 64'h0000_001C_0000_0018);

    // Latency 3, redirect with two lines in flight.
    do_reset(3, 1'b0, 1'b1);
    @(negedge clk);
    imem_req_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    imem_req_ready = 1'b0;
    check("sq_inflight", req_log.size(), 64'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    clear_logs();
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("sq_req0", req_log[0], 64'h40);
    check("sq_first_pc", pp0[0], 64'h40);
    check("sq_first_insn", pi0[0], 64'h40);
    check("sq_first_valid", pv[0], 64'h3);
    check("sq_second_pc", pp0[1], 64'h48);

    // Consumer stall: queue fills to QDEPTH and requests stop.
    do_reset(1, 1'b1, 1'b0);
    repeat (12) @(negedge clk);
    check("stall_req_valid", imem_req_valid, 64'h0);
    check("stall_nreq", req_log.size(), 64'd4);
    check("stall_head_valid", out_valid, 64'h3);
    check("stall_head_pc", out_pc[31:0], 64'h0);
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("drain_pc%0d", i), pp0[i], 64'(32'h8 * i));
    end

    // I-cache backpressure: address held, no duplicate or skipped line.
    do_reset(1, 1'b1, 1'b1);
    @(negedge clk);
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("hold_addr%0d", i), {imem_req_valid, imem_req_addr}, {31'h0, 1'b1, 32'h8});
      @(negedge clk);
    end
    imem_req_ready = 1'b1;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_req%0d", i), req_log[i], 64'(32'h8 * i));
    end
    check("bp_pop2", pp0[2], 64'h10);

    // Reset with three queued entries.
    do_reset(1, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("mid_head_valid", out_valid, 64'h3);
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 64'h0);
    check("mid_rst_req_valid", imem_req_valid, 64'h0);
    check("mid_rst_pc", out_pc, 64'h0);
    @(negedge clk);
    clear_logs();
    reset = 1'b0;
    #1;
    check("post_rst_out_valid", out_valid, 64'h0);
    check("post_rst_req", {imem_req_valid, imem_req_addr}, {31'h0, 1'b1, 32'h0});
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_req0", req_log[0], 64'h0);
    check("post_rst_pop0", pp0[0], 64'h0);
    check("post_rst_pop1", pp0[1], 64'h8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
